// File: rtl/demux_stream_1xn.sv
// 1-to-N packet stream demultiplexer: the first beat's select locks a channel for the whole packet,
// out-of-range selects drop the packet, and a single output register feeds every channel.
module demux_stream_1xn #(
  parameter int N_OUT  = 16,
  parameter int DATA_W = 8,
  localparam int SEL_W = (N_OUT <= 2) ? 1 : $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SEL_W-1:0]  s_sel,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic              m_last,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

  logic [1:0]        r_state;
  logic              r_full;
  logic [SEL_W-1:0]  r_ch;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [15:0]       r_drop_cnt;

  logic              w_sel_ok;
  logic              w_ch_ready;
  logic              w_accept;
  logic              w_load;
  logic              w_drain;
  logic              w_drop_done;
  logic [SEL_W-1:0]  w_dst;
  logic [1:0]        w_state_nxt;

  assign w_sel_ok = ({1'b0, s_sel} < N_OUT_L);

  always_comb begin
    w_ch_ready = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (r_ch == i[SEL_W-1:0] && m_ready[i]) w_ch_ready = 1'b1;
    end
  end

  always_comb begin
    if (rst)                    s_ready = 1'b0;
    else if (r_state == ST_DROP) s_ready = 1'b1;
    else                        s_ready = !r_full || w_ch_ready;
  end

  assign w_accept = s_valid && s_ready;
  assign w_drain  = r_full && w_ch_ready;
  assign w_load   = w_accept && ((r_state == ST_IDLE && w_sel_ok) || r_state == ST_PKT);
  assign w_drop_done = w_accept && s_last &&
                       ((r_state == ST_IDLE && !w_sel_ok) || r_state == ST_DROP);

  // Inside a packet every load targets the channel of its first beat, which r_ch still holds.
  assign w_dst = (r_state == ST_IDLE) ? s_sel : r_ch;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !s_last) w_state_nxt = w_sel_ok ? ST_PKT : ST_DROP;
      ST_PKT:  if (w_accept && s_last) w_state_nxt = ST_IDLE;
      ST_DROP: if (w_accept && s_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_full     <= 1'b0;
      r_ch       <= '0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      // A load wins over a drain so a full register refills without a bubble.
      if (w_load) begin
        r_full <= 1'b1;
        r_data <= s_data;
        r_last <= s_last;
        r_ch   <= w_dst;
      end else if (w_drain) begin
        r_full <= 1'b0;
      end
      if (w_drop_done && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_comb begin
    m_valid = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (r_full && r_ch == i[SEL_W-1:0]) m_valid[i] = 1'b1;
    end
  end

  assign m_data   = r_data;
  assign m_last   = r_last;
  assign drop_cnt = r_drop_cnt;
  assign busy     = (r_state != ST_IDLE) || r_full;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Bench for demux_stream_1xn: four instances (N_OUT = 2, 12, 16, 32) with directed packets
// and random traffic, scored against a packet-level reference model per instance.
module tb_demux_stream_1xn;

  typedef struct packed {
    logic [4:0] ch;
    logic       last;
    logic [7:0] d;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input int cfg, input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL N%0d.%s: got=%0h want=%0h at %0t", cfg, tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int NO = (g == 0) ? 2 : (g == 1) ? 12 : (g == 2) ? 16 : 32;
    localparam int SW = (NO <= 2) ? 1 : $clog2(NO);

    logic          rst = 1'b1;
    logic [7:0]    s_data;
    logic [SW-1:0] s_sel;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [7:0]    m_data;
    logic [NO-1:0] m_valid;
    logic [NO-1:0] m_ready;
    logic          m_last;
    logic [15:0]   drop_cnt;
    logic          busy;
    logic          done = 1'b0;

    logic          rand_rdy = 1'b0;
    logic [NO-1:0] rdy_dir;
    logic [NO-1:0] rdy_rnd = '1;
    assign m_ready = rand_rdy ? rdy_rnd : rdy_dir;

    demux_stream_1xn #(.N_OUT(NO), .DATA_W(8)) u_dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_sel(s_sel), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last), .drop_cnt(drop_cnt), .busy(busy)
    );

    // Reference model: packet state plus the ordered list of routed beats not yet delivered.
    beat_t q[$];
    bit    in_pkt = 0;
    bit    dropping = 0;
    int    lock = 0;
    int    exp_drops = 0;
    bit    after_rst = 0;

    always @(negedge clk) begin
      beat_t e;
      bit    exp_rdy;
      if (rst) begin
        chk(NO, "s_ready_in_rst", 64'(s_ready), 64'd0);
        q.delete();
        in_pkt = 0; dropping = 0; exp_drops = 0; after_rst = 1;
      end else begin
        if (after_rst) begin
          chk(NO, "rst_m_valid", 64'(m_valid), 64'd0);
          chk(NO, "rst_busy", 64'(busy), 64'd0);
          chk(NO, "rst_m_data", 64'(m_data), 64'd0);
          chk(NO, "rst_m_last", 64'(m_last), 64'd0);
          after_rst = 0;
        end
        chk(NO, "drop_cnt", 64'(drop_cnt), 64'(exp_drops));
        chk(NO, "onehot0", 64'($onehot0(m_valid)), 64'd1);
        chk(NO, "full", 64'(m_valid != '0), 64'(q.size() != 0));
        exp_rdy = dropping || q.size() == 0 || m_ready[q[0].ch];
        chk(NO, "s_ready", 64'(s_ready), 64'(exp_rdy));
        chk(NO, "busy", 64'(busy), 64'(in_pkt || dropping || q.size() != 0));
        if (q.size() != 0) begin
          e = q[0];
          chk(NO, "m_valid", 64'(m_valid), 64'd1 << e.ch);
          chk(NO, "m_data", 64'(m_data), 64'(e.d));
          chk(NO, "m_last", 64'(m_last), 64'(e.last));
          if (m_ready[e.ch]) void'(q.pop_front());
        end
        if (s_valid && s_ready) begin
          e.d = s_data;
          e.last = s_last;
          if (in_pkt) begin
            e.ch = 5'(lock);
            q.push_back(e);
            if (s_last) in_pkt = 0;
          end else if (dropping) begin
            if (s_last) begin
              dropping = 0;
              if (exp_drops < 65535) exp_drops++;
            end
          end else if (int'(s_sel) < NO) begin
            e.ch = 5'(s_sel);
            q.push_back(e);
            if (!s_last) begin in_pkt = 1; lock = int'(s_sel); end
          end else if (s_last) begin
            if (exp_drops < 65535) exp_drops++;
          end else begin
            dropping = 1;
          end
        end
      end
    end

    always @(posedge clk) begin
      #1;
      for (int i = 0; i < NO; i++) rdy_rnd[i] = ($urandom_range(0, 9) < 7);
    end

    task automatic send(input int sel, input int d, input bit last);
      int t;
      s_valid = 1'b1; s_sel = SW'(sel); s_data = 8'(d); s_last = last;
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 200) begin @(negedge clk); t++; end
      if (!s_ready) chk(NO, "s_ready_timeout", 64'(s_ready), 64'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic do_reset();
      s_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    endtask

    initial begin
      s_valid = 1'b0; s_sel = '0; s_data = '0; s_last = 1'b0; rdy_dir = '1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      if (NO == 16) begin
        send(3, 8'h11, 0); send(9, 8'h22, 0); send(1, 8'h33, 1);
        idle(3);
        rdy_dir[5] = 1'b0;
        fork
          begin send(5, 8'hA1, 0); send(5, 8'hA2, 1); end
          begin repeat (4) @(posedge clk); #1 rdy_dir[5] = 1'b1; end
        join
        idle(3);
        send(2, 8'h44, 1); send(9, 8'h55, 1);
        idle(3);
        rdy_dir = '0;
        send(3, 8'h66, 0);
        do_reset();
        rdy_dir = '1;
        send(7, 8'h77, 1);
        idle(3);
      end
      if (NO == 12) begin
        send(13, 8'h01, 0); send(2, 8'h02, 0); send(0, 8'h03, 1);
        idle(2);
        send(13, 8'h04, 1);
        idle(2);
        send(11, 8'h05, 1); send(12, 8'h06, 1); send(0, 8'h07, 1);
        idle(3);
      end
      rand_rdy = 1'b1;
      for (int p = 0; p < 300; p++) begin
        int len;
        int sel;
        len = $urandom_range(1, 4);
        sel = $urandom_range(0, (1 << SW) - 1);
        for (int b = 0; b < len; b++) begin
          if ($urandom_range(0, 99) < 2) begin
            do_reset();
            break;
          end
          send(sel, $urandom_range(0, 255), b == len - 1);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
      end
      idle(5);
      done = 1'b1;
    end
  end

  initial begin
    int cyc;
    bit all_done;
    cyc = 0;
    all_done = 0;
    while (!all_done && cyc < 80000) begin
      @(posedge clk);
      cyc++;
      all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done;
    end
    chk(0, "all_done", 64'(all_done), 64'd1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_stream_1xn.md
DEMUX_STREAM_1XN -- requirements
Module: demux_stream_1xn

Interface
REQ-001 Parameter N_OUT, default 16, meaning number of output channels; legal range 2..32, power of two not required.
REQ-002 Parameter DATA_W, default 8, meaning payload width in bits; legal range 1..64.
REQ-003 Derived localparam SEL_W = max(1, ceil(log2(N_OUT))), meaning select width; not user-overridable.
REQ-004 Port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, meaning reset; synchronous and active-high.
REQ-006 Port s_data, input, DATA_W, meaning input beat payload.
REQ-007 Port s_sel, input, SEL_W, meaning destination channel; sampled only on a packet's first beat.
REQ-008 Port s_valid, input, 1, meaning the input beat is present.
REQ-009 Port s_last, input, 1, meaning the input beat is the final beat of its packet.
REQ-010 Port s_ready, output, 1, meaning the block accepts the beat this cycle; a beat transfers when s_valid && s_ready.
REQ-011 Port m_data, output, DATA_W, meaning payload shared by all channels.
REQ-012 Port m_valid, output, N_OUT, meaning per-channel valid; one-hot or zero.
REQ-013 Port m_ready, input, N_OUT, meaning per-channel ready; a channel transfers when m_valid[i] && m_ready[i].
REQ-014 Port m_last, output, 1, meaning the last flag of the beat currently on m_data.
REQ-015 Port drop_cnt, output, 16, meaning the count of dropped packets.
REQ-016 Port busy, output, 1, meaning a packet is in progress or the output register is occupied.

Function
REQ-017 The block SHALL have one output register holding {data, last, channel, full}; m_valid[ch] = full, and all other m_valid bits SHALL be 0.
REQ-018 Latency: a beat accepted at edge k SHALL appear on m_data/m_last/m_valid at edge k (visible cycle k+1); no combinational s_data->m_data path.
REQ-019 The FSM SHALL have three states: IDLE (awaiting the first beat), PKT (channel locked), DROP (discarding the packet).
REQ-020 IDLE, beat accepted, s_sel < N_OUT: the beat goes to channel s_sel, the channel is locked, and the FSM goes to PKT; if s_last=1 it stays in IDLE.
REQ-021 IDLE, beat accepted, s_sel >= N_OUT: the beat is discarded and the FSM goes to DROP; if s_last=1 it stays in IDLE and the drop is counted immediately.
REQ-022 PKT: every accepted beat goes to the locked channel and s_sel is ignored; an accepted beat with s_last=1 returns the FSM to IDLE.
REQ-023 DROP: s_ready=1 and beats are discarded; the beat with s_last=1 returns the FSM to IDLE.
REQ-024 In IDLE/PKT, s_ready SHALL be (!full || m_ready[channel]), so a full register drains and reloads in the same cycle with no bubble.
REQ-025 Simultaneous drain and load SHALL leave full=1 with new contents; drain without load SHALL clear full.
REQ-026 Back-to-back packets to different channels SHALL incur no idle cycle; the register may hold channel a while the next first beat targets channel b.
REQ-027 drop_cnt SHALL increment by 1 per dropped packet, on its s_last beat, and saturate at 16'hFFFF.
REQ-028 m_data/m_last SHALL hold their last loaded value while full=0; they are not qualified.
REQ-029 busy SHALL be (state != IDLE) || full.
REQ-030 If N_OUT is a power of two, DROP SHALL be unreachable.

Reset
REQ-031 While rst=1 at a clock edge, the following SHALL hold: state=IDLE, full=0, m_valid=0, m_data=0, m_last=0, drop_cnt=0, busy=0.
REQ-032 Reset mid-packet SHALL abandon the packet and discard any buffered beat; the next accepted beat is treated as a first beat.
REQ-033 s_ready SHALL be 0 during reset.

Verification
REQ-034 N_OUT=16, DATA_W=8, m_ready=all 1: beats 0x11(sel=3), 0x22, 0x33(last) -> m_valid=16'h0008 for three consecutive cycles with data 0x11, 0x22, 0x33, and m_last only on 0x33.
REQ-035 N_OUT=16: hold m_ready[5]=0 during a 2-beat packet to sel=5 -> s_ready=0 after the first beat; raise m_ready[5] -> both beats are delivered in order with no loss or duplication.
REQ-036 N_OUT=12: 3-beat packet with sel=13 -> s_ready=1 throughout, m_valid stays 0, and drop_cnt 0 -> 1 after the last beat; then a 1-beat packet sel=13 -> drop_cnt=2.
REQ-037 N_OUT=16: packet sel=2 (last) immediately followed by sel=9 (last), m_ready=all 1 -> m_valid=0x0004 then 0x0200 in consecutive cycles.
REQ-038 Assert rst for one cycle in PKT with full=1 -> next cycle m_valid=0 and busy=0; a following beat with sel=7 routes to channel 7.
REQ-039 Random stimulus at N_OUT in {2,12,16,32}: the scoreboard SHALL show per-channel in-order delivery, m_valid one-hot-or-zero, and drop_cnt equal to the count of packets with sel>=N_OUT.
